// File: rtl/logic_processor_4_bit_if.sv
// logic_processor_4_bit_if: switch/button inputs and register outputs of the logic processor
interface logic_processor_4_bit_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] D;
    logic             Load_A;
    logic             Load_B;
    logic [2:0]       F;
    logic [1:0]       R;
    logic             Execute;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    modport master (output D, Load_A, Load_B, F, R, Execute, input A, B);
    modport slave (input D, Load_A, Load_B, F, R, Execute, output A, B);
endinterface

// File: rtl/logic_processor_4_bit.sv
// logic_processor_4_bit: bit-serial logic unit over two shift registers; define LOGIC_PROC_SYNC_INPUTS_EN to synchronize Execute/Load_A/Load_B
module logic_processor_4_bit #(parameter int WIDTH = 4) (
    input logic CLK,
    input logic Reset,
    logic_processor_4_bit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t state, state_next;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] reg_a, reg_b;
    logic execute, load_a, load_b, bit_a, bit_b, base, f, in_a, in_b, last;
`ifdef LOGIC_PROC_SYNC_INPUTS_EN
    logic [1:0] sync_exec, sync_la, sync_lb;
    // two-flop synchronizers for the button-driven controls
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync_exec <= '0;
            sync_la <= '0;
            sync_lb <= '0;
        end else begin
            sync_exec <= {sync_exec[0], bus.Execute};
            sync_la <= {sync_la[0], bus.Load_A};
            sync_lb <= {sync_lb[0], bus.Load_B};
        end
    end
    assign execute = sync_exec[1];
    assign load_a = sync_la[1];
    assign load_b = sync_lb[1];
`else
    assign execute = bus.Execute;
    assign load_a = bus.Load_A;
    assign load_b = bus.Load_B;
`endif
    assign bit_a = reg_a[0];
    assign bit_b = reg_b[0];
    assign last = count == CW'(WIDTH - 1);
    // F[2] inverts the base function: AND/OR/XOR/ONE become NAND/NOR/XNOR/ZERO
    always_comb begin
        base = F_base(bus.F[1:0], bit_a, bit_b);
        f = bus.F[2] ^ base;
        in_a = bus.R == 2'b10 ? f : bus.R == 2'b11 ? bit_b : bit_a;
        in_b = bus.R == 2'b01 ? f : bus.R == 2'b11 ? bit_a : bit_b;
    end
    function automatic logic F_base(input logic [1:0] sel, input logic a, input logic b);
        return sel[1] ? (sel[0] ? 1'b1 : a ^ b) : (sel[0] ? a | b : a & b);
    endfunction
    // HOLD waits for Execute release so a held button cannot retrigger
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (execute ? SHIFT : IDLE) :
                     state == SHIFT ? (last ? (execute ? HOLD : IDLE) : SHIFT) :
                     (execute ? HOLD : IDLE);
    end
    // registers shift while in SHIFT, otherwise accept parallel loads
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            reg_a <= '0;
            reg_b <= '0;
        end else begin
            state <= state_next;
            if (state == SHIFT) begin
                reg_a <= {in_a, reg_a[WIDTH-1:1]};
                reg_b <= {in_b, reg_b[WIDTH-1:1]};
                count <= last ? '0 : count + 1'b1;
            end else begin
                count <= '0;
                if (load_a) reg_a <= bus.D;
                if (load_b) reg_b <= bus.D;
            end
        end
    end
    assign bus.A = reg_a;
    assign bus.B = reg_b;
endmodule

// File: tb/tb_logic_processor_4_bit.sv
// tb_logic_processor_4_bit: randomized and directed check of logic_processor_4_bit against a behavioural model
module tb_logic_processor_4_bit;
    localparam int W = 4;
    logic CLK = 0;
    logic Reset = 1;
    int checks = 0;
    int failures = 0;
    logic_processor_4_bit_if #(.WIDTH(W)) bus();
    logic_processor_4_bit #(.WIDTH(W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));
    always #5 CLK = ~CLK;
    // truth tables indexed by {a,b}
    logic [3:0] fn_table [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1111, 4'b0111, 4'b0001, 4'b1001, 4'b0000};
    logic [W-1:0] ma, mb;
    int rem = 0;
    bit hold_wait = 0;
    bit started = 0;
    logic [1:0] ex_d = 0, la_d = 0, lb_d = 0;
    // model: a run of W pending shifts, then wait for Execute release
    always @(posedge CLK) begin
        bit ex, la, lb, a, b, f, ina, inb;
`ifdef LOGIC_PROC_SYNC_INPUTS_EN
        ex = ex_d[1];
        la = la_d[1];
        lb = lb_d[1];
        ex_d <= Reset ? 2'b00 : {ex_d[0], bus.Execute};
        la_d <= Reset ? 2'b00 : {la_d[0], bus.Load_A};
        lb_d <= Reset ? 2'b00 : {lb_d[0], bus.Load_B};
`else
        ex = bus.Execute;
        la = bus.Load_A;
        lb = bus.Load_B;
`endif
        if (Reset) begin
            ma <= 0;
            mb <= 0;
            rem <= 0;
            hold_wait <= 0;
            started <= 1;
        end else if (rem > 0) begin
            a = ma[0];
            b = mb[0];
            f = fn_table[bus.F][2 * a + b];
            ina = bus.R == 2 ? f : bus.R == 3 ? b : a;
            inb = bus.R == 1 ? f : bus.R == 3 ? a : b;
            ma <= (ma >> 1) | (W'(ina) << (W - 1));
            mb <= (mb >> 1) | (W'(inb) << (W - 1));
            rem <= rem - 1;
            if (rem == 1) hold_wait <= ex;
        end else begin
            if (la) ma <= bus.D;
            if (lb) mb <= bus.D;
            if (hold_wait) hold_wait <= ex;
            else if (ex) rem <= W;
        end
    end
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask
    // every-cycle comparison against the model
    always @(negedge CLK) begin
        if (started) begin
            check("model_A", bus.A, ma);
            check("model_B", bus.B, mb);
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask
    task automatic load(input logic [W-1:0] va, input logic [W-1:0] vb);
        bus.D = va;
        bus.Load_A = 1;
        tick(1);
        bus.Load_A = 0;
        bus.D = vb;
        bus.Load_B = 1;
        tick(1);
        bus.Load_B = 0;
        tick(3);
    endtask
    task automatic op(input logic [2:0] fsel, input logic [1:0] rsel);
        bus.F = fsel;
        bus.R = rsel;
        bus.Execute = 1;
        tick(1);
        bus.Execute = 0;
        tick(W + 4);
    endtask
    initial begin
        bus.D = 0;
        bus.Load_A = 0;
        bus.Load_B = 0;
        bus.F = 0;
        bus.R = 0;
        bus.Execute = 0;
        tick(2);
        Reset = 0;
        load(4'b1111, 4'b1111);
        bus.F = 3'b011;
        bus.R = 2'b01;
        bus.Execute = 1;
        Reset = 1;
        tick(1);
        check("reset_A", bus.A, 4'b0000);
        check("reset_B", bus.B, 4'b0000);
        Reset = 0;
        bus.Execute = 0;
        tick(6);
        check("no_shift_after_reset_B", bus.B, 4'b0000);
        load(4'b1010, 4'b0101);
        check("load_A", bus.A, 4'b1010);
        check("load_B", bus.B, 4'b0101);
        op(3'b010, 2'b01);
        check("xor_r01_A", bus.A, 4'b1010);
        check("xor_r01_B", bus.B, 4'b1111);
        tick(50);
        check("idle_stable_B", bus.B, 4'b1111);
        load(4'b1010, 4'b0101);
        op(3'b000, 2'b10);
        check("and_r10_A", bus.A, 4'b0000);
        check("and_r10_B", bus.B, 4'b0101);
        load(4'b1010, 4'b0101);
        op(3'b000, 2'b11);
        check("swap_A", bus.A, 4'b0101);
        check("swap_B", bus.B, 4'b1010);
        load(4'b1010, 4'b0101);
        op(3'b110, 2'b00);
        check("rotate_A", bus.A, 4'b1010);
        check("rotate_B", bus.B, 4'b0101);
        load(4'b1010, 4'b0101);
        bus.R = 2'b11;
        bus.Execute = 1;
        tick(20);
        check("held_once_A", bus.A, 4'b0101);
        bus.Execute = 0;
        tick(3);
        bus.Execute = 1;
        tick(1);
        bus.Execute = 0;
        tick(W + 4);
        check("retrigger_A", bus.A, 4'b1010);
        load(4'b1010, 4'b0101);
        bus.Execute = 1;
        tick(1);
        bus.Execute = 0;
        tick(1);
        bus.D = 4'b1111;
        bus.Load_A = 1;
        tick(1);
        bus.Load_A = 0;
        tick(W + 4);
        check("load_ignored_A", bus.A, 4'b0101);
        check("load_ignored_B", bus.B, 4'b1010);
        load(4'b1010, 4'b0101);
        bus.Execute = 1;
        tick(1);
        bus.Execute = 0;
        tick(2);
        Reset = 1;
        tick(1);
        Reset = 0;
        check("abort_A", bus.A, 4'b0000);
        check("abort_B", bus.B, 4'b0000);
        load(4'b1100, 4'b0011);
        op(3'b000, 2'b11);
        check("after_abort_A", bus.A, 4'b0011);
        check("after_abort_B", bus.B, 4'b1100);
        for (int i = 0; i < 600; i++) begin
            Reset = $urandom_range(0, 59) == 0;
            bus.Execute = $urandom_range(0, 3) == 0 ? ~bus.Execute : bus.Execute;
            bus.Load_A = $urandom_range(0, 4) == 0;
            bus.Load_B = $urandom_range(0, 4) == 0;
            bus.D = W'($urandom);
            bus.F = 3'($urandom);
            bus.R = 2'($urandom);
            tick(1);
        end
        Reset = 0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
